// File: rtl/despacho_preempcao_if.sv
// Timer/PC-side signal bundle of the preemption responder.
// master drives the requests and boundaries; slave is the responder itself.
interface despacho_preempcao_if;
    logic        timer;
    logic [31:0] pcAtual;
    logic        instr_fim;
    logic        eret;
    logic        desvio;
    logic [31:0] pcDesvio;
    logic [31:0] epc;
    logic        modo_kernel;
    logic [31:0] preempcoes;

    modport master (
        output timer, pcAtual, instr_fim, eret,
        input  desvio, pcDesvio, epc, modo_kernel, preempcoes
    );

    modport slave (
        input  timer, pcAtual, instr_fim, eret,
        output desvio, pcDesvio, epc, modo_kernel, preempcoes
    );
endinterface

// File: rtl/despacho_preempcao.sv
// Preemption responder: saves user PC at a boundary, jumps to VETOR, returns on eret.
// Latency: boundary at edge k -> PC load during k+1; no backpressure, timer is a held level.
module despacho_preempcao #(
    parameter logic [31:0] VETOR          = 32'd100,
    parameter logic [31:0] LIMITE_USUARIO = 32'd3000
) (
    input  logic                     clock_auto,
    input  logic                     reset_n,
    despacho_preempcao_if.slave      bus
);

    typedef enum logic [2:0] {
        USUARIO  = 3'd0,
        PENDENTE = 3'd1,
        DESVIA   = 3'd2,
        KERNEL   = 3'd3,
        RETORNA  = 3'd4
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [31:0] epc_q;
    logic [31:0] preempcoes_q;
    logic        epc_we;
    logic        conta_inc;

    always_ff @(posedge clock_auto or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= USUARIO;
            epc_q        <= 32'd0;
            preempcoes_q <= 32'd0;
        end else begin
            estado_q <= estado_d;
            if (epc_we)
                epc_q <= bus.pcAtual;
            if (conta_inc)
                preempcoes_q <= preempcoes_q + 32'd1;
        end
    end

    always_comb begin
        estado_d         = estado_q;
        epc_we           = 1'b0;
        conta_inc        = 1'b0;
        bus.desvio       = 1'b0;
        bus.pcDesvio     = 32'd0;
        bus.modo_kernel  = 1'b0;
        unique case (estado_q)
            USUARIO: begin
                // A boundary in the same cycle as the request never counts.
                if (bus.timer && (bus.pcAtual >= LIMITE_USUARIO))
                    estado_d = PENDENTE;
            end
            PENDENTE: begin
                if (!bus.timer) begin
                    estado_d = USUARIO;
                end else if (bus.instr_fim) begin
                    epc_we   = 1'b1;
                    estado_d = DESVIA;
                end
            end
            DESVIA: begin
                bus.desvio      = 1'b1;
                bus.pcDesvio    = VETOR;
                bus.modo_kernel = 1'b1;
                conta_inc       = 1'b1;
                estado_d        = KERNEL;
            end
            KERNEL: begin
                bus.modo_kernel = 1'b1;
                if (bus.eret)
                    estado_d = RETORNA;
            end
            RETORNA: begin
                bus.desvio      = 1'b1;
                bus.pcDesvio    = epc_q;
                bus.modo_kernel = 1'b1;
                estado_d        = USUARIO;
            end
            default: estado_d = USUARIO;
        endcase
    end

    assign bus.epc        = epc_q;
    assign bus.preempcoes = preempcoes_q;

endmodule

// File: tb/tb_despacho_preempcao.sv
// Directed bench for despacho_preempcao: inputs change 1 time unit after each
// rising edge and outputs are checked at that same point.
module tb_despacho_preempcao;

    logic clock_auto = 1'b0;
    logic reset_n    = 1'b1;
    int   total      = 0;
    int   bad        = 0;

    despacho_preempcao_if bus ();

    despacho_preempcao #(
        .VETOR          (32'd100),
        .LIMITE_USUARIO (32'd3000)
    ) dut (
        .clock_auto (clock_auto),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    always #5 clock_auto = ~clock_auto;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic d, input logic [31:0] pcd,
                           input logic mk, input logic [31:0] e, input logic [31:0] c);
        chk1 ({tag, ".desvio"},      bus.desvio,      d);
        chk32({tag, ".pcDesvio"},    bus.pcDesvio,    pcd);
        chk1 ({tag, ".modo_kernel"}, bus.modo_kernel, mk);
        chk32({tag, ".epc"},         bus.epc,         e);
        chk32({tag, ".preempcoes"},  bus.preempcoes,  c);
    endtask

    task automatic step();
        @(posedge clock_auto);
        #1;
    endtask

    initial begin
        bus.timer     = 1'b0;
        bus.pcAtual   = 32'd0;
        bus.instr_fim = 1'b0;
        bus.eret      = 1'b0;

        // Reset between edges must clear the outputs without a clock edge.
        #2 reset_n = 1'b0;
        #1 chk_all("rst_async", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk_all("rst_idle", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

        // Basic preemption at pc 3050.
        bus.pcAtual = 32'd3050;
        bus.timer   = 1'b1;
        step();
        chk_all("pend0", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        chk_all("pend2", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        bus.instr_fim = 1'b1;
        step();
        chk_all("desvia1", 1'b1, 32'd100, 1'b1, 32'd3050, 32'd0);
        bus.instr_fim = 1'b0;
        bus.timer     = 1'b0;
        bus.pcAtual   = 32'd100;
        step();
        chk_all("kernel1", 1'b0, 32'd0, 1'b1, 32'd3050, 32'd1);
        step();
        chk_all("kernel1b", 1'b0, 32'd0, 1'b1, 32'd3050, 32'd1);

        // Return to the saved address.
        bus.eret = 1'b1;
        step();
        chk_all("retorna1", 1'b1, 32'd3050, 1'b1, 32'd3050, 32'd1);
        bus.eret = 1'b0;
        step();
        chk_all("user1", 1'b0, 32'd0, 1'b0, 32'd3050, 32'd1);

        // Cancelled request leaves epc alone.
        bus.pcAtual = 32'd3100;
        bus.timer   = 1'b1;
        step();
        chk_all("cancel_pend", 1'b0, 32'd0, 1'b0, 32'd3050, 32'd1);
        bus.timer = 1'b0;
        step();
        bus.instr_fim = 1'b1;
        step();
        chk_all("cancel_user", 1'b0, 32'd0, 1'b0, 32'd3050, 32'd1);
        bus.instr_fim = 1'b0;

        // Kernel-space request just below the user limit is ignored.
        bus.pcAtual   = 32'd2999;
        bus.timer     = 1'b1;
        bus.instr_fim = 1'b1;
        step();
        step();
        chk_all("kspace", 1'b0, 32'd0, 1'b0, 32'd3050, 32'd1);

        // Request at exactly the limit with a same-cycle boundary: waits for the next one.
        bus.pcAtual = 32'd3000;
        step();
        chk_all("simul_pend", 1'b0, 32'd0, 1'b0, 32'd3050, 32'd1);
        step();
        chk_all("simul_desvia", 1'b1, 32'd100, 1'b1, 32'd3000, 32'd1);
        bus.instr_fim = 1'b0;
        bus.eret      = 1'b1;
        step();
        chk_all("eret_in_desvia", 1'b0, 32'd0, 1'b1, 32'd3000, 32'd2);
        bus.eret = 1'b0;
        step();
        chk_all("kernel2", 1'b0, 32'd0, 1'b1, 32'd3000, 32'd2);
        bus.timer = 1'b0;
        bus.eret  = 1'b1;
        step();
        chk_all("retorna2", 1'b1, 32'd3000, 1'b1, 32'd3000, 32'd2);
        step();
        chk_all("eret_in_user", 1'b0, 32'd0, 1'b0, 32'd3000, 32'd2);
        bus.eret = 1'b0;

        // Counter wrap.
        force dut.preempcoes_q = 32'hFFFF_FFFF;
        #1;
        release dut.preempcoes_q;
        #1;
        chk32("forced_cnt", bus.preempcoes, 32'hFFFF_FFFF);
        bus.pcAtual = 32'd4000;
        bus.timer   = 1'b1;
        step();
        bus.instr_fim = 1'b1;
        step();
        chk_all("wrap_desvia", 1'b1, 32'd100, 1'b1, 32'd4000, 32'hFFFF_FFFF);
        bus.instr_fim = 1'b0;
        bus.timer     = 1'b0;
        step();
        chk_all("wrap_kernel", 1'b0, 32'd0, 1'b1, 32'd4000, 32'd0);

        // Async reset in KERNEL.
        #2 reset_n = 1'b0;
        #1 chk_all("rst_kernel", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk_all("post_rst", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
